// File: rtl/regfile_immgen_pkg.sv
// Shared types for the decode-stage operand block: format codes, opcodes and
// instruction field views.
package regfile_immgen_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  typedef enum logic [2:0] {
    FmtNop = 3'd0,
    FmtR   = 3'd1,
    FmtI   = 3'd2,
    FmtS   = 3'd3,
    FmtB   = 3'd4,
    FmtU   = 3'd5,
    FmtJ   = 3'd6
  } format_t;

  localparam logic [6:0] I_OP    = 7'b0010011;
  localparam logic [6:0] S_OP    = 7'b0100011;
  localparam logic [6:0] L_OP    = 7'b0000011;
  localparam logic [6:0] LUI_OP  = 7'b0110111;
  localparam logic [6:0] AUI_OP  = 7'b0010111;
  localparam logic [6:0] JAL_OP  = 7'b1101111;
  localparam logic [6:0] JALR_OP = 7'b1100111;
  localparam logic [6:0] B_OP    = 7'b1100011;
  localparam logic [6:0] RR_OP   = 7'b0110011;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } itype_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } stype_t;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm4_1;
    logic       imm11;
    logic [6:0] opcode;
  } btype_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } utype_t;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm10_1;
    logic       imm11;
    logic [7:0] imm19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } jtype_t;

  typedef union packed {
    itype_t itype;
    stype_t stype;
    btype_t btype;
    utype_t utype;
    jtype_t jtype;
  } instruction_t;

endpackage

// File: rtl/regfile_immgen_if.sv
// Decoder/writeback-facing bus of the operand block.
interface regfile_immgen_if;
  import regfile_immgen_pkg::*;

  logic [31:0]     instr_i;
  logic [2:0]      format_i;
  logic [XLEN-1:0] imm_o;
  logic [AW-1:0]   i_raddr_a;
  logic [AW-1:0]   i_raddr_b;
  logic            i_wen;
  logic [AW-1:0]   i_waddr;
  logic [XLEN-1:0] i_wdata;
  logic [XLEN-1:0] o_rdata_a;
  logic [XLEN-1:0] o_rdata_b;

  modport master (
    output instr_i, format_i, i_raddr_a, i_raddr_b, i_wen, i_waddr, i_wdata,
    input  imm_o, o_rdata_a, o_rdata_b
  );

  modport slave (
    input  instr_i, format_i, i_raddr_a, i_raddr_b, i_wen, i_waddr, i_wdata,
    output imm_o, o_rdata_a, o_rdata_b
  );
endinterface

// File: rtl/imm_generator.sv
// Combinational RV32I immediate generator, selected by decoder format code.
module imm_generator
  import regfile_immgen_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [2:0]      format_i,
  output logic [XLEN-1:0] imm_o
);

  instruction_t    w_instr;
  logic            w_s;
  logic [XLEN-1:0] w_imm_i;

  assign w_instr = instr_i;
  assign w_s     = instr_i[31];
  assign w_imm_i = {{20{w_s}}, w_instr.itype.imm};

  always_comb begin
    imm_o = '0;
    case (format_i)
      FmtI: imm_o = w_imm_i;
      FmtS: imm_o = {{20{w_s}}, w_instr.stype.imm_hi, w_instr.stype.imm_lo};
      FmtB: imm_o = {{19{w_s}}, w_instr.btype.imm12, w_instr.btype.imm11,
                     w_instr.btype.imm10_5, w_instr.btype.imm4_1, 1'b0};
      FmtU: imm_o = {w_instr.utype.imm, 12'b0};
      FmtJ: begin
        // The decoder tags JALR as J format; it still carries an I immediate.
        if (w_instr.jtype.opcode == JALR_OP) begin
          imm_o = w_imm_i;
        end else begin
          imm_o = {{11{w_s}}, w_instr.jtype.imm20, w_instr.jtype.imm19_12,
                   w_instr.jtype.imm11, w_instr.jtype.imm10_1, 1'b0};
        end
      end
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero.
module regfile_2r1w
  import regfile_immgen_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_raddr_a,
  input  logic [AW-1:0]   i_raddr_b,
  input  logic            i_wen,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wen && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Bypass is gated by rst so reads stay zero for the whole reset window.
  always_comb begin
    o_rdata_a = '0;
    if (i_raddr_a != '0) begin
      if (i_wen && !rst && (i_waddr == i_raddr_a)) begin
        o_rdata_a = i_wdata;
      end else begin
        o_rdata_a = r_regs[i_raddr_a];
      end
    end
  end

  always_comb begin
    o_rdata_b = '0;
    if (i_raddr_b != '0) begin
      if (i_wen && !rst && (i_waddr == i_raddr_b)) begin
        o_rdata_b = i_wdata;
      end else begin
        o_rdata_b = r_regs[i_raddr_b];
      end
    end
  end

endmodule

// File: rtl/regfile_immgen.sv
// Decode-stage operand block: register file plus immediate generator.
module regfile_immgen
  import regfile_immgen_pkg::*;
(
  input logic             clk,
  input logic             rst,
  regfile_immgen_if.slave bus
);

  imm_generator u_imm_generator (
    .instr_i  (bus.instr_i),
    .format_i (bus.format_i),
    .imm_o    (bus.imm_o)
  );

  regfile_2r1w u_regfile_2r1w (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (bus.i_raddr_a),
    .i_raddr_b (bus.i_raddr_b),
    .i_wen     (bus.i_wen),
    .i_waddr   (bus.i_waddr),
    .i_wdata   (bus.i_wdata),
    .o_rdata_a (bus.o_rdata_a),
    .o_rdata_b (bus.o_rdata_b)
  );

endmodule

// File: tb/tb_regfile_immgen.sv
// Randomized scoreboard bench for regfile_immgen against a behavioural model.
module tb_regfile_immgen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_immgen_if bus ();

  regfile_immgen u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [32];
  logic        pend_wen = 1'b0;
  logic [4:0]  pend_waddr = '0;
  logic [31:0] pend_wdata = '0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] sext(input logic [31:0] x, input int w);
    logic [31:0] one;
    one = 32'd1;
    if (x[w-1]) return x - (one << w);
    return x;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] fmt);
    logic [31:0] v;
    v = '0;
    case (fmt)
      3'd2: v = sext({20'd0, ins[31:20]}, 12);
      3'd3: v = sext({20'd0, ins[31:25], ins[11:7]}, 12);
      3'd4: v = sext({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      3'd5: v = {ins[31:12], 12'd0};
      3'd6: begin
        if (ins[6:0] == 7'b1100111) v = sext({20'd0, ins[31:20]}, 12);
        else v = sext({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] ra, input logic rs,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
    if (rs || ra == 5'd0) return '0;
    if (we && wa == ra) return wd;
    return model[ra];
  endfunction

  // One stimulus cycle: applies the previous cycle's write to the model at the
  // edge, drives new inputs, optionally raises rst mid-cycle, then queues the
  // expectation for the monitor's negedge sample.
  task automatic drive(input logic [31:0] ins, input logic [2:0] fmt,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r_now, input logic r_mid);
    exp_t e;
    @(posedge clk);
    if (pend_wen && !rst && pend_waddr != 5'd0) model[pend_waddr] = pend_wdata;
    #1;
    rst = r_now;
    bus.instr_i   = ins;
    bus.format_i  = fmt;
    bus.i_raddr_a = ra;
    bus.i_raddr_b = rb;
    bus.i_wen     = we;
    bus.i_waddr   = wa;
    bus.i_wdata   = wd;
    if (r_mid) begin
      #2;
      rst = 1'b1;
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end
    e.imm = ref_imm(ins, fmt);
    e.a   = ref_read(ra, rst, we, wa, wd);
    e.b   = ref_read(rb, rst, we, wa, wd);
    q.push_back(e);
    pend_wen   = we;
    pend_waddr = wa;
    pend_wdata = wd;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    drive(32'h0, 3'd0, 5'd0, 5'd0, 1'b1, wa, wd, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
    drive(32'h0, 3'd0, ra, rb, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic imm_chk(input logic [31:0] ins, input logic [2:0] fmt);
    drive(ins, fmt, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (bus.imm_o !== e.imm) begin
          bad++;
          $display("FAIL imm: got %h want %h (instr %h fmt %0d)", bus.imm_o, e.imm,
                   bus.instr_i, bus.format_i);
        end
        total++;
        if (bus.o_rdata_a !== e.a) begin
          bad++;
          $display("FAIL rdata_a: got %h want %h (raddr %0d)", bus.o_rdata_a, e.a,
                   bus.i_raddr_a);
        end
        total++;
        if (bus.o_rdata_b !== e.b) begin
          bad++;
          $display("FAIL rdata_b: got %h want %h (raddr %0d)", bus.o_rdata_b, e.b,
                   bus.i_raddr_b);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] ins;
    int          guard;
    for (int i = 0; i < 32; i++) model[i] = '0;
    bus.instr_i = '0; bus.format_i = '0; bus.i_raddr_a = '0; bus.i_raddr_b = '0;
    bus.i_wen = 1'b0; bus.i_waddr = '0; bus.i_wdata = '0;

    // Reset state: every register reads zero while rst is held.
    drive(32'h0, 3'd0, 5'd5, 5'd31, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    drive(32'h0, 3'd0, 5'd1, 5'd17, 1'b1, 5'd1, 32'h55, 1'b1, 1'b0);
    drive(32'h0, 3'd0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle clears a live register before the next edge.
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd0);
    drive(32'h0, 3'd0, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    drive(32'h0, 3'd0, 5'd5, 5'd1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    rd(5'd5, 5'd31);

    // Basic write/read and x0 discard.
    wr(5'd1, 32'h12345678);
    wr(5'd31, 32'hFFFFFFFF);
    rd(5'd1, 5'd31);
    wr(5'd0, 32'hAAAA5555);
    rd(5'd0, 5'd0);

    // Same-cycle bypass, then persistence after the edge.
    drive(32'h0, 3'd0, 5'd7, 5'd1, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 1'b0);
    rd(5'd7, 5'd7);
    drive(32'h0, 3'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h11111111, 1'b0, 1'b0);

    // Directed immediates.
    imm_chk(32'hFFF00093, 3'd2);
    imm_chk(32'h0020A423, 3'd3);
    imm_chk(32'hFE000EE3, 3'd4);
    imm_chk(32'h123452B7, 3'd5);
    imm_chk(32'h001000EF, 3'd6);
    imm_chk(32'hFF808067, 3'd6);
    imm_chk(32'hFFF00093, 3'd1);
    imm_chk(32'hFFF00093, 3'd0);
    imm_chk(32'hFFF00093, 3'd7);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[6:0] = 7'b1100111;
      drive(ins, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0);
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
